// File: rtl/warp_issue_sched.sv
// Round-robin warp issue scheduler: grants one eligible warp per cycle, registers
// the issue word, and tracks in-flight warps through a fixed-latency retire pipe.
module warp_issue_sched #(
  parameter int NUM_WARPS     = 8,
  parameter int WARP_ID_WIDTH = 3,
  parameter int CONTROL_WIDTH = 21,
  parameter int EXEC_LATENCY  = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_WARPS-1:0]               req,
  input  logic [NUM_WARPS*CONTROL_WIDTH-1:0] req_control,
  input  logic                               stall,
  output logic [NUM_WARPS-1:0]               grant,
  output logic                               issue_valid,
  output logic [WARP_ID_WIDTH-1:0]           issue_warp,
  output logic [CONTROL_WIDTH-1:0]           issue_control,
  output logic                               retire_valid,
  output logic [WARP_ID_WIDTH-1:0]           retire_warp,
  output logic [NUM_WARPS-1:0]               busy,
  output logic                               idle
);

  logic [WARP_ID_WIDTH-1:0] ptr_q, ptr_d;
  logic [NUM_WARPS-1:0]     busy_q, busy_d;
  logic                     issue_valid_q, issue_valid_d;
  logic [WARP_ID_WIDTH-1:0] issue_warp_q, issue_warp_d;
  logic [CONTROL_WIDTH-1:0] issue_control_q, issue_control_d;

  logic [EXEC_LATENCY-1:0]  pipe_valid_q, pipe_valid_d, pipe_in_valid;
  logic [WARP_ID_WIDTH-1:0] pipe_warp_q [EXEC_LATENCY];
  logic [WARP_ID_WIDTH-1:0] pipe_warp_d [EXEC_LATENCY];
  logic [WARP_ID_WIDTH-1:0] pipe_in_warp [EXEC_LATENCY];

  logic [NUM_WARPS-1:0]     eligible;
  logic [NUM_WARPS-1:0]     grant_oh;
  logic                     grant_any;
  logic [WARP_ID_WIDTH-1:0] grant_idx;
  logic [WARP_ID_WIDTH-1:0] scan_idx;
  logic                     retire_accept;

  // Grant is also masked during reset so nothing is acknowledged that will be discarded.
  assign eligible      = (stall || rst) ? '0 : (req & ~busy_q);
  assign retire_accept = pipe_valid_q[EXEC_LATENCY-1] && !stall;

  always_comb begin
    grant_oh  = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_WARPS; k++) begin
      scan_idx = WARP_ID_WIDTH'((int'(ptr_q) + k) % NUM_WARPS);
      if (!grant_any && eligible[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
    if (grant_any) grant_oh[grant_idx] = 1'b1;
  end

  always_comb begin
    ptr_d           = ptr_q;
    busy_d          = busy_q;
    issue_valid_d   = issue_valid_q;
    issue_warp_d    = issue_warp_q;
    issue_control_d = issue_control_q;
    if (!stall) begin
      issue_valid_d = grant_any;
      if (grant_any) begin
        issue_warp_d    = grant_idx;
        issue_control_d = req_control[grant_idx*CONTROL_WIDTH +: CONTROL_WIDTH];
        ptr_d = (grant_idx == WARP_ID_WIDTH'(NUM_WARPS - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
    // A granted warp is never busy, so clear and set cannot hit the same bit.
    if (retire_accept) busy_d[pipe_warp_q[EXEC_LATENCY-1]] = 1'b0;
    if (grant_any)     busy_d[grant_idx] = 1'b1;
  end

  for (genvar gi = 0; gi < EXEC_LATENCY; gi++) begin : g_pipe
    if (gi == 0) begin : g_head
      assign pipe_in_valid[gi] = issue_valid_q;
      assign pipe_in_warp[gi]  = issue_warp_q;
    end else begin : g_body
      assign pipe_in_valid[gi] = pipe_valid_q[gi-1];
      assign pipe_in_warp[gi]  = pipe_warp_q[gi-1];
    end
  end

  always_comb begin
    pipe_valid_d = stall ? pipe_valid_q : pipe_in_valid;
    for (int k = 0; k < EXEC_LATENCY; k++) begin
      pipe_warp_d[k] = stall ? pipe_warp_q[k] : pipe_in_warp[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q           <= '0;
      busy_q          <= '0;
      issue_valid_q   <= 1'b0;
      issue_warp_q    <= '0;
      issue_control_q <= '0;
      pipe_valid_q    <= '0;
      for (int k = 0; k < EXEC_LATENCY; k++) pipe_warp_q[k] <= '0;
    end else begin
      ptr_q           <= ptr_d;
      busy_q          <= busy_d;
      issue_valid_q   <= issue_valid_d;
      issue_warp_q    <= issue_warp_d;
      issue_control_q <= issue_control_d;
      pipe_valid_q    <= pipe_valid_d;
      for (int k = 0; k < EXEC_LATENCY; k++) pipe_warp_q[k] <= pipe_warp_d[k];
    end
  end

  assign grant         = grant_oh;
  assign issue_valid   = issue_valid_q;
  assign issue_warp    = issue_warp_q;
  assign issue_control = issue_control_q;
  assign retire_valid  = pipe_valid_q[EXEC_LATENCY-1];
  assign retire_warp   = pipe_warp_q[EXEC_LATENCY-1];
  assign busy          = busy_q;
  assign idle          = (busy_q == '0) && !issue_valid_q;

endmodule
